// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller.
// The PC mux imports the SEL_* encodings from this package.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_IMM    = 2'b01;
    localparam logic [1:0] SEL_RESULT = 2'b10;
    localparam logic [1:0] SEL_RSTVEC = 2'b11;

endpackage

// File: rtl/trigger_sync.sv
// Two-flop synchronizer plus rising-edge detector for asynchronous
// button-level inputs. A held level produces a single one-cycle pulse.
module trigger_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);

    // sync_q[0] = first stage, sync_q[1] = synchronized level,
    // sync_q[2] = synchronized level delayed by one cycle.
    logic [2:0] sync_q;

    // Shift the async level through the synchronizer and edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], async_i};
    end

    assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: PC load enable, next-PC select, stall and
// flush lines, and the IDLE/RUN/HALT life-cycle started by trigger.
// Optional feature macro: FETCH_PERF_EN adds saturating perf counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger,
    input  logic                 pcsrc,
    input  logic                 jalr,
    input  logic                 load_use,
    input  logic                 halt_req,
    output logic                 pc_en,
    output logic [1:0]           next_sel,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 running
`ifdef FETCH_PERF_EN
   ,output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic         trig_edge;
    logic         lu_win;

    trigger_sync u_trig (
        .clk    (clk),
        .rst    (rst),
        .async_i(trigger),
        .edge_o (trig_edge)
    );

    // State register; async reset returns straight to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and outputs; RUN outputs follow hazard inputs combinationally.
    // Redirects win over load_use because the stalled instruction is squashed.
    always_comb begin
        state_d  = state_q;
        pc_en    = 1'b1;
        next_sel = SEL_RSTVEC;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b1;
        flush_e  = 1'b1;
        running  = 1'b0;
        lu_win   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig_edge) state_d = RUN;
            end
            RUN: begin
                running  = 1'b1;
                next_sel = SEL_PC4;
                if (halt_req) begin
                    pc_en   = 1'b0;
                    state_d = HALT;
                end else if (jalr) begin
                    next_sel = SEL_RESULT;
                end else if (pcsrc) begin
                    next_sel = SEL_IMM;
                end else if (load_use) begin
                    pc_en   = 1'b0;
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_d = 1'b0;
                    lu_win  = 1'b1;
                end else begin
                    flush_d = 1'b0;
                    flush_e = 1'b0;
                end
            end
            HALT: begin
                pc_en    = 1'b0;
                next_sel = SEL_PC4;
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                flush_d  = 1'b0;
                flush_e  = 1'b0;
                if (trig_edge) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FETCH_PERF_EN
    logic [CNT_WIDTH-1:0] cycle_q, instret_q, stall_q;
    logic                 in_run;
    logic                 start_run;

    assign in_run    = (state_q == RUN);
    assign start_run = (state_q == IDLE) && trig_edge;

    // Saturating RUN-time counters, cleared on every fresh start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
            stall_q   <= '0;
        end else if (start_run) begin
            cycle_q   <= '0;
            instret_q <= '0;
            stall_q   <= '0;
        end else if (in_run) begin
            if (cycle_q != '1)
                cycle_q <= cycle_q + CNT_WIDTH'(1);
            if (pc_en && next_sel == SEL_PC4 && instret_q != '1)
                instret_q <= instret_q + CNT_WIDTH'(1);
            if (lu_win && stall_q != '1)
                stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign stall_cnt   = stall_q;
`else
    logic unused_perf;
    assign unused_perf = lu_win ^ (CNT_WIDTH != 0);
`endif

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the PC datapath: decides every cycle whether the PC register loads and which next-PC source the PC mux selects (sequential, branch/jal target, jalr target, reset vector). It also drives the fetch/decode stall and decode/execute flush lines to the pipeline registers. It owns the run/halt life-cycle started by the external `trigger` input. It sits beside the PC block in the top level, taking resolved control-flow and hazard information from the execute stage and the hazard unit.

## Interface
Parameters:
- `CNT_WIDTH`, 32: width of the performance counters (used only with `FETCH_PERF_EN`)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `trigger` in 1: asynchronous start/restart request (button level)
- `pcsrc` in 1: taken branch or jal resolved in execute
- `jalr` in 1: jalr resolved in execute (target = `result`)
- `load_use` in 1: load-use stall request from the hazard unit
- `halt_req` in 1: halt instruction (ebreak) in execute
- `pc_en` out 1: PC register write enable
- `next_sel` out 2: 00 pc+4, 01 pc+immext, 10 result, 11 reset vector
- `stall_f` out 1: hold fetch/decode register
- `stall_d` out 1: hold the PC-side decode copy
- `flush_d` out 1: clear the fetch/decode register
- `flush_e` out 1: clear the decode/execute register
- `running` out 1: high in RUN
- `cycle_cnt`, `instret_cnt`, `stall_cnt` out `CNT_WIDTH` each: present only with `FETCH_PERF_EN`

## Operation
- `trigger` passes through a 2-flop synchronizer. `trig_edge` = sync2 & ~sync2_d.
- FSM states are IDLE, RUN and HALT. Reset state is IDLE.
- IDLE:
  - Outputs: `pc_en`=1, `next_sel`=11, `flush_d`=`flush_e`=1, stalls 0, `running`=0.
  - On `trig_edge` -> RUN.
- RUN: combinational priority, highest first.
  1. `halt_req`: `pc_en`=0, `flush_d`=`flush_e`=1, next state HALT.
  2. `jalr`: `pc_en`=1, `next_sel`=10, `flush_d`=`flush_e`=1.
  3. `pcsrc`: `pc_en`=1, `next_sel`=01, `flush_d`=`flush_e`=1.
  4. `load_use`: `pc_en`=0, `stall_f`=`stall_d`=1, `flush_e`=1, `next_sel`=00.
  5. Otherwise: `pc_en`=1, `next_sel`=00, no stall, no flush.
- A redirect overrides a simultaneous `load_use`, because the stalled instruction is squashed. `jalr` and `pcsrc` high together resolve as jalr.
- `trig_edge` has no effect in RUN.
- HALT:
  - Outputs: `pc_en`=0, stalls 1, flushes 0, `running`=0. The PC and pipeline are frozen.
  - On `trig_edge` -> IDLE, which restarts from the reset vector.
- All other inputs are ignored outside RUN.

## Timing
- Reset values:
  - State IDLE, synchronizer flops 0, counters 0.
  - Outputs take IDLE values: `pc_en`=1, `next_sel`=11, `flush_d`=`flush_e`=1, `stall_f`=`stall_d`=0, `running`=0.
- Reset asserted mid-operation forces IDLE immediately, without waiting for a clock edge.
- Outputs are a Moore/Mealy mix:
  - In RUN, outputs respond in the same cycle to `pcsrc`, `jalr`, `load_use` and `halt_req`.
  - The state changes at the next rising edge.
- Trigger latency: `trigger` is high before edge k. sync1 is set at k, sync2 at k+1, `trig_edge` is high during cycle k+1..k+2. The state changes at edge k+2.
- `trigger` must be high across at least one rising edge. Holding it high gives a single edge.
- `halt_req` in cycle n sets `running` low from edge n+1.

## Configuration
- `FETCH_PERF_EN` defined:
  - Counters exist.
  - `cycle_cnt` +1 every RUN cycle.
  - `instret_cnt` +1 every RUN cycle with `pc_en`=1 and `next_sel`=00.
  - `stall_cnt` +1 every RUN cycle with `load_use` winning.
  - All three clear on reset and on the IDLE->RUN transition, and saturate at all-ones.
- `FETCH_PERF_EN` undefined: the counters and their ports are absent. All other behaviour is identical.

## Structure
- Package `fetch_ctrl_pkg` holds:
  - the state enum `fetch_state_t` (IDLE, RUN, HALT);
  - `next_sel` constants `SEL_PC4`, `SEL_IMM`, `SEL_RESULT`, `SEL_RSTVEC`, which the PC mux shares.
- Sub-module `trigger_sync`: 2-flop synchronizer plus rising-edge detector, with `clk`/`rst`. It is reused for other button inputs.

## Test plan
- Release reset with `trigger`=0 for 10 cycles -> `pc_en`=1, `next_sel`=11, `running`=0 throughout. Pulse `trigger` for 1 cycle before edge k -> `running`=1 from edge k+2.
- In RUN, `pcsrc`=1 for one cycle -> that cycle shows `next_sel`=01, `flush_d`=`flush_e`=1, `pc_en`=1. The following cycle shows `next_sel`=00.
- In RUN, `load_use`=1 and `jalr`=1 together -> `next_sel`=10, `pc_en`=1, `stall_f`=0. Then `load_use` alone for 2 cycles -> `pc_en`=0, `stall_f`=1, `flush_e`=1 for both cycles.
- In RUN, `halt_req`=1 -> HALT, `pc_en`=0 held for 20 cycles despite `pcsrc` toggling. A trigger pulse -> IDLE (`next_sel`=11), and a second pulse -> RUN.
- Assert `rst` asynchronously mid-RUN, between edges -> outputs show IDLE values before the next edge. Counters read 0 with `FETCH_PERF_EN`.
- With `FETCH_PERF_EN`: 5 RUN cycles made of 3 sequential, 1 load_use and 1 pcsrc -> `cycle_cnt`=5, `instret_cnt`=3, `stall_cnt`=1.
